// File: rtl/spi_slave.sv
// spi_slave: SPI responder (SCK idle high, sample on rise, MSB first)
// with DATA/STATUS/CTRL bus registers and DEPTH-deep RX/TX byte FIFOs.
// Ports: clk_i/rst_ni (async active-low), bus adr_i/sel_i/stb_i/we_i/
// dat_i/dat_o/ack_o, SPI spiClk_i/spiMosi_i/spiMiso_o, and spiCs_ni
// only when the macro SPI_SLAVE_CS_EN is defined.
module spi_slave #(
   parameter int         DEPTH = 8,
   parameter logic [7:0] FILL  = 8'hFF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:2]  adr_i,
   input  logic [3:0]  sel_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   input  logic        spiClk_i,
   input  logic        spiMosi_i,
   output logic        spiMiso_o
`ifdef SPI_SLAVE_CS_EN
   ,
   input  logic        spiCs_ni
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [2:0] sckSync;
   logic [1:0] mosiSync;
   logic       csHigh;

   logic [2:0] bitcnt;
   logic [7:0] rxsh, txsh, fill;
   logic       txOverflow, rxOverflow, txUnderrun;

   logic [7:0]    rxMem [DEPTH];
   logic [7:0]    txMem [DEPTH];
   logic [AW-1:0] rxWp, rxRp, txWp, txRp;
   logic [7:0]    rxCnt, txCnt;

   logic rxEmpty, rxFull, txEmpty, txFull, busy;
   logic wr, rd, dataWr, ctrlWr0, ctrlWr1, clrFlags, resync;
   logic sckRise, sckFall;
   logic rxPushReq, rxPush, rxPop, txPush, txPopReq, txPop;
   logic [7:0] rxByte;
   logic unusedOk;

   assign unusedOk = ^{dat_i[31:16], dat_i[7:2], sel_i[3:2]};

`ifdef SPI_SLAVE_CS_EN
   logic [1:0] csSync;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) csSync <= 2'b11;
      else         csSync <= {csSync[0], spiCs_ni};
   end
   assign csHigh = csSync[1];
`else
   assign csHigh = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sckSync  <= 3'b111;
         mosiSync <= 2'b00;
      end else begin
         sckSync  <= {sckSync[1:0], spiClk_i};
         mosiSync <= {mosiSync[0], spiMosi_i};
      end
   end

   assign wr       = stb_i & we_i;
   assign rd       = stb_i & ~we_i;
   assign dataWr   = wr & (adr_i == 2'd0) & sel_i[0];
   assign ctrlWr0  = wr & (adr_i == 2'd2) & sel_i[0];
   assign ctrlWr1  = wr & (adr_i == 2'd2) & sel_i[1];
   assign clrFlags = ctrlWr0 & dat_i[0];
   assign resync   = ctrlWr0 & dat_i[1];

   // Resync and a raised CS both suppress any SCK edge seen that cycle.
   assign sckRise = sckSync[1] & ~sckSync[2] & ~resync & ~csHigh;
   assign sckFall = ~sckSync[1] & sckSync[2] & ~resync & ~csHigh;

   assign rxEmpty = (rxCnt == 8'd0);
   assign rxFull  = (rxCnt == 8'(DEPTH));
   assign txEmpty = (txCnt == 8'd0);
   assign txFull  = (txCnt == 8'(DEPTH));
   assign busy    = (bitcnt != 3'd0) & ~csHigh;

   assign rxByte    = {rxsh[6:0], mosiSync[1]};
   assign rxPushReq = sckRise & (bitcnt == 3'd7);
   // Fullness is taken before any same-cycle pop.
   assign rxPush    = rxPushReq & ~rxFull;
   assign rxPop     = rd & (adr_i == 2'd0) & ~rxEmpty;
   assign txPush    = dataWr & ~txFull;
   assign txPopReq  = sckFall & (bitcnt == 3'd0);
   assign txPop     = txPopReq & ~txEmpty;

   always_ff @(posedge clk_i) begin
      if (rxPush) rxMem[rxWp] <= rxByte;
      if (txPush) txMem[txWp] <= dat_i[7:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rxWp  <= '0;
         rxRp  <= '0;
         rxCnt <= '0;
         txWp  <= '0;
         txRp  <= '0;
         txCnt <= '0;
      end else begin
         if (rxPush) rxWp <= nextPtr(rxWp);
         if (rxPop)  rxRp <= nextPtr(rxRp);
         if (txPush) txWp <= nextPtr(txWp);
         if (txPop)  txRp <= nextPtr(txRp);
         rxCnt <= rxCnt + {7'd0, rxPush} - {7'd0, rxPop};
         txCnt <= txCnt + {7'd0, txPush} - {7'd0, txPop};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bitcnt     <= '0;
         rxsh       <= '0;
         txsh       <= 8'h80;
         spiMiso_o  <= 1'b1;
         fill       <= FILL;
         txOverflow <= 1'b0;
         rxOverflow <= 1'b0;
         txUnderrun <= 1'b0;
      end else begin
         if (resync || csHigh) begin
            bitcnt <= '0;
            rxsh   <= '0;
         end else if (sckRise) begin
            rxsh   <= rxByte;
            bitcnt <= bitcnt + 3'd1;
         end
         if (sckFall) begin
            if (bitcnt == 3'd0) txsh <= txEmpty ? fill : txMem[txRp];
            else                txsh <= {txsh[6:0], 1'b0};
         end
         spiMiso_o <= csHigh | txsh[7];
         if (ctrlWr1) fill <= dat_i[15:8];
         // A flag raised in the same cycle as a clear stays set.
         if (clrFlags) begin
            txOverflow <= 1'b0;
            rxOverflow <= 1'b0;
            txUnderrun <= 1'b0;
         end
         if (rxPushReq && rxFull)  rxOverflow <= 1'b1;
         if (dataWr && txFull)     txOverflow <= 1'b1;
         if (txPopReq && txEmpty)  txUnderrun <= 1'b1;
      end
   end

   assign ack_o = stb_i;

   always_comb begin
      dat_o = '0;
      case (adr_i)
         2'd0: dat_o = {24'd0, rxEmpty ? 8'h00 : rxMem[rxRp]};
         2'd1: dat_o = {txCnt, rxCnt, 9'd0, txOverflow, rxOverflow,
                        txUnderrun, busy, txFull, ~rxEmpty, rxEmpty};
         2'd2: dat_o = {16'd0, fill, 8'd0};
         default: dat_o = '0;
      endcase
   end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized bench for spi_slave with a queue-based
// reference model of the FIFOs, sticky flags and SPI byte exchange.
module tb_spi_slave;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic [1:0]  adr = 2'd0;
   logic [3:0]  sel = 4'h0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic [31:0] datIn = '0;
   logic [31:0] datOut;
   logic        ack;
   logic        sck = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic        csN = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   logic       txOv = 1'b0, rxOv = 1'b0, txUn = 1'b0;
   logic [7:0] fillM = 8'hFF;

   always #5 clk = ~clk;

   spi_slave #(.DEPTH(D), .FILL(8'hFF)) dut (
      .clk_i(clk), .rst_ni(rstN), .adr_i(adr), .sel_i(sel),
      .stb_i(stb), .we_i(we), .dat_i(datIn), .dat_o(datOut),
      .ack_o(ack), .spiClk_i(sck), .spiMosi_i(mosi),
      .spiMiso_o(miso)
`ifdef SPI_SLAVE_CS_EN
      , .spiCs_ni(csN)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] expStatus(input logic busyM);
      return {8'(txq.size()), 8'(rxq.size()), 9'd0, txOv, rxOv, txUn,
              busyM, txq.size() == D, rxq.size() != 0, rxq.size() == 0};
   endfunction

   task automatic busWrite(input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      @(negedge clk);
      adr = a; datIn = d; sel = s; we = 1'b1; stb = 1'b1;
      @(posedge clk);
      #1 stb = 1'b0; we = 1'b0;
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      adr = a; we = 1'b0; stb = 1'b1;
      #1 d = datOut;
      @(posedge clk);
      #1 stb = 1'b0;
   endtask

   task automatic txWrite(input logic [7:0] b);
      busWrite(2'd0, {24'd0, b}, 4'h1);
      if (txq.size() < D) txq.push_back(b);
      else txOv = 1'b1;
   endtask

   task automatic rxReadCheck(input string tag);
      logic [31:0] d;
      logic [7:0]  e;
      busRead(2'd0, d);
      e = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
      check(tag, d, {24'd0, e});
   endtask

   task automatic statusCheck(input string tag, input logic busyM);
      logic [31:0] d;
      busRead(2'd1, d);
      check(tag, d, expStatus(busyM));
   endtask

   // What the slave shifts out for a byte starting now.
   task automatic modelStart(output logic [7:0] e);
      if (txq.size() != 0) e = txq.pop_front();
      else begin
         e = fillM;
         txUn = 1'b1;
      end
   endtask

   task automatic modelEnd(input logic [7:0] b);
      if (rxq.size() < D) rxq.push_back(b);
      else rxOv = 1'b1;
   endtask

   task automatic spiBits(input logic [7:0] mo, input int n,
                          output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sck = 1'b0;
         mosi = mo[7-i];
         repeat (6) @(negedge clk);
         sck = 1'b1;
         mi[7-i] = miso;
         repeat (5) @(negedge clk);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic xferCheck(input string tag, input logic [7:0] mo);
      logic [7:0] e, mi;
      modelStart(e);
      spiBits(mo, 8, mi);
      modelEnd(mo);
      check(tag, {24'd0, mi}, {24'd0, e});
   endtask

   task automatic drain();
      while (rxq.size() != 0) rxReadCheck("drain");
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  e, mi;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      repeat (3) @(negedge clk);

      check("rstMiso", {31'd0, miso}, 32'd1);
      statusCheck("rstStatus", 1'b0);
      busRead(2'd2, d);
      check("rstCtrl", d, 32'h0000FF00);
      @(negedge clk);
      adr = 2'd3; stb = 1'b1;
      #1 check("adr3", datOut, 32'd0);
      check("ack", {31'd0, ack}, 32'd1);
      @(posedge clk);
      #1 stb = 1'b0;

      txWrite(8'hA5);
      xferCheck("xferA5", 8'h3C);
      statusCheck("rxNew1", 1'b0);
      rxReadCheck("rx3C");
      statusCheck("rxNew0", 1'b0);

      busWrite(2'd2, 32'h00005A00, 4'h2);
      fillM = 8'h5A;
      busRead(2'd2, d);
      check("ctrlFill", d, 32'h00005A00);
      xferCheck("under", 8'($urandom));
      statusCheck("underFlag", 1'b0);
      busWrite(2'd2, 32'h1, 4'h1);
      txOv = 1'b0; rxOv = 1'b0; txUn = 1'b0;
      statusCheck("underClr", 1'b0);
      drain();

      for (int i = 0; i < 9; i++) xferCheck("rxOvX", 8'($urandom));
      statusCheck("rxOvStat", 1'b0);
      drain();
      rxReadCheck("rxEmptyRd");

      busWrite(2'd2, 32'h1, 4'h1);
      txOv = 1'b0; rxOv = 1'b0; txUn = 1'b0;
      busWrite(2'd0, 32'h77, 4'h2);
      statusCheck("selGate", 1'b0);
      for (int i = 0; i < 9; i++) txWrite(8'($urandom));
      statusCheck("txOvStat", 1'b0);
      for (int i = 0; i < 8; i++) xferCheck("txOvX", 8'($urandom));
      drain();

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(1, 0) != 0) txWrite(8'($urandom));
         if ($urandom_range(2, 0) != 0) xferCheck("rndX", 8'($urandom));
         if ($urandom_range(1, 0) != 0) rxReadCheck("rndRd");
         statusCheck("rndStat", 1'b0);
      end
      drain();

      modelStart(e);
      spiBits(8'hF0, 3, mi);
      statusCheck("busy", 1'b1);
      busWrite(2'd2, 32'h2, 4'h1);
      statusCheck("resync", 1'b0);
      xferCheck("postResync", 8'h96);
      rxReadCheck("rxResync");

`ifdef SPI_SLAVE_CS_EN
      drain();
      modelStart(e);
      spiBits(8'hFF, 4, mi);
      csN = 1'b1;
      repeat (6) @(negedge clk);
      check("csMiso", {31'd0, miso}, 32'd1);
      csN = 1'b0;
      repeat (6) @(negedge clk);
      xferCheck("cs81", 8'h81);
      rxReadCheck("rx81");
`endif

      txWrite(8'h3E);
      modelStart(e);
      spiBits(8'hC3, 4, mi);
      @(negedge clk);
      rstN = 1'b0;
      #1 check("midRstMiso", {31'd0, miso}, 32'd1);
      adr = 2'd1;
      #1 check("midRstStat", datOut, 32'h1);
      rxq.delete(); txq.delete();
      txOv = 1'b0; rxOv = 1'b0; txUn = 1'b0; fillM = 8'hFF;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      repeat (3) @(negedge clk);
      xferCheck("postRst", 8'h6D);
      rxReadCheck("rxPostRst");
      statusCheck("finalStat", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
